// File: rtl/serial_sub_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and default geometry constants.
package serial_sub_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// 1-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Built from gate primitives so the cell maps one-to-one onto a netlist.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb, na, nx, t1, t2;

    xor g_x0 (axb, a, b);
    xor g_x1 (d, axb, bin);
    not g_n0 (na, a);
    and g_a0 (t1, na, b);
    not g_n1 (nx, axb);
    and g_a1 (t2, nx, bin);
    or  g_o0 (bout, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, result = A - B, one bit per clock,
// LSB first. Start/done handshake; result and flags hold until the next
// accepted start.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output and
// makes isLessThan a signed compare; otherwise isLessThan is unsigned.
module serial_subtractor
    import serial_sub_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_result,
    output logic             borrow_out,
    output logic             isNotEqual,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             isLessThan
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr, b_sr, shadow;
    logic             brw, sticky_ne;
    logic             d, bout, last;

    // single shared subtractor cell fed from the shift-register LSBs
    fs_bit u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_OVERFLOW_EN
    // on the last step a_sr[0]/b_sr[0] are the operand sign bits and d is the result sign
    logic ovf_c;
    assign ovf_c = (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // datapath: operand capture, serial shift, borrow chain, result/flag publish
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            a_sr        <= '0;
            b_sr        <= '0;
            shadow      <= '0;
            brw         <= 1'b0;
            sticky_ne   <= 1'b0;
            data_result <= '0;
            borrow_out  <= 1'b0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr      <= data_operandA;
                        b_sr      <= data_operandB;
                        cnt       <= '0;
                        brw       <= 1'b0;
                        sticky_ne <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    shadow    <= {d, shadow[WIDTH-1:1]};
                    brw       <= bout;
                    sticky_ne <= sticky_ne | d;
                    cnt       <= cnt + CNT_W'(1);
                    // publish on DONE entry; visible outputs stay frozen during RUN
                    if (last) begin
                        data_result <= {d, shadow[WIDTH-1:1]};
                        borrow_out  <= bout;
                        isNotEqual  <= sticky_ne | d;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow    <= ovf_c;
                        isLessThan  <= d ^ ovf_c;
`else
                        isLessThan  <= bout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=32).
// Build with SERIAL_SUB_OVERFLOW_EN defined to cover the signed variant.
module tb_serial_subtractor;

    localparam int W = 32;

    logic         clock, reset, start;
    logic [W-1:0] data_operandA, data_operandB;
    logic         ready, busy, done, borrow_out, isNotEqual, isLessThan;
    logic [W-1:0] data_result;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] last_res = '0;

    serial_subtractor #(.WIDTH(W), .CNT_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .data_result   (data_result),
        .borrow_out    (borrow_out),
        .isNotEqual    (isNotEqual),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .overflow      (overflow),
`endif
        .isLessThan    (isLessThan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // present operands with start and let the accepting edge pass
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // full transaction with latency, hold-during-run and result checks
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ebo, input logic ene,
                          input logic elt);
        int lat;
        chk({tag, ".ready_pre"}, W'(ready), W'(1));
        start_op(a, b);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (n == 10) begin
                chk({tag, ".busy_mid"}, W'(busy), W'(1));
                chk({tag, ".hold_mid"}, data_result, last_res);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, ".latency"}, W'(lat), W'(W));
        chk({tag, ".result"}, data_result, er);
        chk({tag, ".borrow"}, W'(borrow_out), W'(ebo));
        chk({tag, ".ne"}, W'(isNotEqual), W'(ene));
        chk({tag, ".lt"}, W'(isLessThan), W'(elt));
        @(posedge clock);
        #1;
        chk({tag, ".done_1cyc"}, W'(done), W'(0));
        chk({tag, ".ready_post"}, W'(ready), W'(1));
        last_res = er;
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.ready", W'(ready), W'(1));
        chk("rst.busy", W'(busy), W'(0));
        chk("rst.done", W'(done), W'(0));
        chk("rst.result", data_result, '0);
        chk("rst.flags", W'({borrow_out, isNotEqual, isLessThan}), W'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_op("sub5_3", 32'd5, 32'd3, 32'd2, 1'b0, 1'b1, 1'b0);
        run_op("sub3_5", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
        run_op("equal", 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        run_op("minint", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        chk("minint.ovf", W'(overflow), W'(1));
        run_op("noovf", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
        chk("noovf.ovf", W'(overflow), W'(0));
`else
        run_op("minint", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`endif
        run_op("wrap0_1", 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);

        // starts while busy, operands changed after accept: ignored
        start_op(32'd100, 32'd58);
        dones = 0;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5 || n == 20) begin
                data_operandA = 32'd1;
                data_operandB = 32'd9;
                start = 1'b1;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) dones++;
        end
        chk("ignore.dones", W'(dones), W'(1));
        chk("ignore.result", data_result, 32'd42);
        chk("ignore.ready", W'(ready), W'(1));
        last_res = 32'd42;

        // reset in the middle of RUN aborts the operation
        start_op(32'd9, 32'd4);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort.ready", W'(ready), W'(1));
        chk("abort.busy", W'(busy), W'(0));
        chk("abort.result", data_result, '0);
        chk("abort.flags", W'({borrow_out, isNotEqual, isLessThan}), W'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        chk("abort.no_done", W'(dones), W'(0));
        last_res = '0;
        run_op("sub7_7", 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
